// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory definitions: request space encodings, BRAM region bases,
// register-file indices and the controller state type.
package chip8_pkg;

  localparam int unsigned PROC_MEM_TYPE_COUNT = 3;
  localparam int unsigned PROC_TYPE_W         = $clog2(PROC_MEM_TYPE_COUNT);

  localparam logic [PROC_TYPE_W-1:0] PROC_MEM_TYPE_RAM   = PROC_TYPE_W'(0);
  localparam logic [PROC_TYPE_W-1:0] PROC_MEM_TYPE_REG   = PROC_TYPE_W'(1);
  localparam logic [PROC_TYPE_W-1:0] PROC_MEM_TYPE_STACK = PROC_TYPE_W'(2);

  localparam logic [12:0] REG_BASE   = 13'h1000;
  localparam logic [12:0] STACK_BASE = 13'h1020;

  localparam logic [4:0] REG_IH  = 5'd16;
  localparam logic [4:0] REG_IL  = 5'd17;
  localparam logic [4:0] REG_PCH = 5'd18;
  localparam logic [4:0] REG_PCL = 5'd19;
  localparam logic [4:0] REG_DT  = 5'd20;
  localparam logic [4:0] REG_ST  = 5'd21;
  localparam logic [4:0] REG_SP  = 5'd22;

  // Register file and stack together span 64 bytes from REG_BASE.
  localparam logic [5:0] INIT_LAST = 6'd63;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } mem_state_t;

endpackage

// File: rtl/chip8_mem_addr_map.sv
// Combinational translation of a typed processor address into a flat BRAM
// address, flagging out-of-range offsets and unknown spaces as illegal.
module chip8_mem_addr_map
  import chip8_pkg::*;
(
  input  logic [PROC_TYPE_W-1:0] mem_type,
  input  logic [11:0]            addr,
  output logic [12:0]            bram_addr,
  output logic                   legal
);

  always_comb begin
    bram_addr = '0;
    legal     = 1'b0;
    case (mem_type)
      PROC_MEM_TYPE_RAM: begin
        bram_addr = {1'b0, addr};
        legal     = 1'b1;
      end
      PROC_MEM_TYPE_REG: begin
        bram_addr = REG_BASE + {8'd0, addr[4:0]};
        legal     = (addr[11:5] == '0);
      end
      PROC_MEM_TYPE_STACK: begin
        bram_addr = STACK_BASE + {8'd0, addr[4:0]};
        legal     = (addr[11:5] == '0);
      end
      default: begin
        bram_addr = '0;
        legal     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/chip8_mem_ctrl.sv
// Single-port BRAM owner for CHIP-8 RAM, registers and stack: clears register
// space after reset, then serves pipelined processor requests or loader writes.
module chip8_mem_ctrl
  import chip8_pkg::*;
#(
  parameter int unsigned BRAM_LATENCY = 2,
  parameter logic [15:0] PC_INIT      = 16'h0200
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   proc_valid_in,
  input  logic                   proc_we_in,
  input  logic [11:0]            proc_addr_in,
  input  logic [7:0]             proc_data_in,
  input  logic [PROC_TYPE_W-1:0] proc_type_in,
  output logic                   proc_ready_out,
  output logic                   proc_valid_out,
  output logic [7:0]             proc_data_out,
  input  logic                   load_active_in,
  input  logic                   load_valid_in,
  input  logic [11:0]            load_addr_in,
  input  logic [7:0]             load_data_in,
  output logic [12:0]            bram_addr_out,
  output logic                   bram_we_out,
  output logic [7:0]             bram_din_out,
  input  logic [7:0]             bram_dout_in,
  output logic                   init_done_out,
  output logic                   error_out
);

  mem_state_t state, next_state;

  logic [5:0]            init_cnt;
  logic [7:0]            init_data;
  logic [12:0]           map_addr;
  logic                  map_legal;
  logic                  accept;
  logic                  rd_accept;
  logic [BRAM_LATENCY:0] rd_pipe;

  chip8_mem_addr_map u_addr_map (
    .mem_type  (proc_type_in),
    .addr      (proc_addr_in),
    .bram_addr (map_addr),
    .legal     (map_legal)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state     = state;
    proc_ready_out = 1'b0;
    case (state)
      ST_INIT: if (init_cnt == INIT_LAST) next_state = ST_RUN;
      ST_RUN:  proc_ready_out = !load_active_in;
      default: next_state = ST_INIT;
    endcase
  end

  assign accept    = proc_valid_in & proc_ready_out;
  assign rd_accept = accept & ~proc_we_in & map_legal;

  always_comb begin
    init_data = '0;
    if (init_cnt == {1'b0, REG_PCH}) init_data = PC_INIT[15:8];
    if (init_cnt == {1'b0, REG_PCL}) init_data = PC_INIT[7:0];
  end

  // Read tag travels BRAM_LATENCY+1 stages so the capture lines up with dout.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      init_cnt       <= '0;
      rd_pipe        <= '0;
      proc_valid_out <= 1'b0;
      proc_data_out  <= '0;
      bram_addr_out  <= '0;
      bram_we_out    <= 1'b0;
      bram_din_out   <= '0;
      init_done_out  <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      bram_we_out    <= 1'b0;
      rd_pipe        <= {rd_pipe[BRAM_LATENCY-1:0], rd_accept};
      proc_valid_out <= rd_pipe[BRAM_LATENCY];
      if (rd_pipe[BRAM_LATENCY]) proc_data_out <= bram_dout_in;

      if (state == ST_INIT) begin
        init_cnt      <= init_cnt + 6'd1;
        bram_addr_out <= REG_BASE + {7'd0, init_cnt};
        bram_we_out   <= 1'b1;
        bram_din_out  <= init_data;
        if (init_cnt == INIT_LAST) init_done_out <= 1'b1;
      end else if (load_active_in) begin
        if (load_valid_in) begin
          bram_addr_out <= {1'b0, load_addr_in};
          bram_we_out   <= 1'b1;
          bram_din_out  <= load_data_in;
        end
      end else if (accept) begin
        if (map_legal) begin
          bram_addr_out <= map_addr;
          bram_we_out   <= proc_we_in;
          bram_din_out  <= proc_data_in;
        end else begin
          error_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chip8_mem_ctrl.sv
// Directed scoreboard bench for chip8_mem_ctrl with a 2-cycle BRAM model.
module tb_chip8_mem_ctrl;

  logic        clk;
  logic        rst_in;
  logic        proc_valid_in;
  logic        proc_we_in;
  logic [11:0] proc_addr_in;
  logic [7:0]  proc_data_in;
  logic [1:0]  proc_type_in;
  logic        proc_ready_out;
  logic        proc_valid_out;
  logic [7:0]  proc_data_out;
  logic        load_active_in;
  logic        load_valid_in;
  logic [11:0] load_addr_in;
  logic [7:0]  load_data_in;
  logic [12:0] bram_addr_out;
  logic        bram_we_out;
  logic [7:0]  bram_din_out;
  logic [7:0]  bram_dout_in;
  logic        init_done_out;
  logic        error_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int init_wr = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] drv_exp;
  logic       drv_legal;

  chip8_mem_ctrl #(.BRAM_LATENCY(2), .PC_INIT(16'h0200)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .proc_valid_in  (proc_valid_in),
    .proc_we_in     (proc_we_in),
    .proc_addr_in   (proc_addr_in),
    .proc_data_in   (proc_data_in),
    .proc_type_in   (proc_type_in),
    .proc_ready_out (proc_ready_out),
    .proc_valid_out (proc_valid_out),
    .proc_data_out  (proc_data_out),
    .load_active_in (load_active_in),
    .load_valid_in  (load_valid_in),
    .load_addr_in   (load_addr_in),
    .load_data_in   (load_data_in),
    .bram_addr_out  (bram_addr_out),
    .bram_we_out    (bram_we_out),
    .bram_din_out   (bram_din_out),
    .bram_dout_in   (bram_dout_in),
    .init_done_out  (init_done_out),
    .error_out      (error_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM: unwritten bytes read as 0x5A so cleared locations are distinguishable.
  bit [7:0] mem     [8192];
  bit       written [8192];
  logic [7:0] rd_stage;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_we_out) begin
      mem[bram_addr_out]     <= bram_din_out;
      written[bram_addr_out] <= 1'b1;
      if (!rst_in && bram_addr_out[12:6] == 7'b1000000) init_wr <= init_wr + 1;
    end
    rd_stage     <= written[bram_addr_out] ? mem[bram_addr_out] : 8'h5A;
    bram_dout_in <= rd_stage;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_valid;
    exp_t e;
    if (!rst_in && proc_valid_in && proc_ready_out && !proc_we_in && drv_legal)
      exp_q.push_back('{data: drv_exp, due: cyc + 4});
    exp_valid = (exp_q.size() != 0) && (exp_q[0].due == cyc);
    chk("valid_strobe", {31'd0, proc_valid_out}, {31'd0, exp_valid});
    if (exp_valid) begin
      e = exp_q.pop_front();
      chk("rd_data", {24'd0, proc_data_out}, {24'd0, e.data});
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic wait_accept(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (proc_ready_out) got = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, "_accepted"}, {31'd0, got}, 32'd1);
  endtask

  task automatic proc_req(input string tag, input logic we, input logic [1:0] typ,
                          input logic [11:0] addr, input logic [7:0] data,
                          input logic legal, input logic [7:0] exp);
    proc_valid_in = 1'b1;
    proc_we_in    = we;
    proc_type_in  = typ;
    proc_addr_in  = addr;
    proc_data_in  = data;
    drv_legal     = legal;
    drv_exp       = exp;
    wait_accept(tag);
  endtask

  task automatic idle();
    proc_valid_in = 1'b0;
    proc_we_in    = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int bad_bytes;
    logic [7:0] ld_data [4];
    ld_data[0] = 8'h12; ld_data[1] = 8'h34; ld_data[2] = 8'h56; ld_data[3] = 8'h78;

    rst_in = 1'b1;
    proc_valid_in = 1'b0; proc_we_in = 1'b0; proc_addr_in = '0;
    proc_data_in = '0; proc_type_in = '0;
    load_active_in = 1'b0; load_valid_in = 1'b0; load_addr_in = '0; load_data_in = '0;
    drv_exp = '0; drv_legal = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, proc_ready_out}, 32'd0);
    chk("rst_we", {31'd0, bram_we_out}, 32'd0);
    chk("rst_addr", {19'd0, bram_addr_out}, 32'd0);
    chk("rst_din", {24'd0, bram_din_out}, 32'd0);
    chk("rst_data", {24'd0, proc_data_out}, 32'd0);
    chk("rst_init_done", {31'd0, init_done_out}, 32'd0);
    chk("rst_error", {31'd0, error_out}, 32'd0);
    base = init_wr;
    rst_in = 1'b0;

    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      chk("init_we", {31'd0, bram_we_out}, 32'd1);
      chk("init_addr", {19'd0, bram_addr_out}, 32'h1000 + k);
      chk("init_din", {24'd0, bram_din_out}, (k == 18) ? 32'h02 : 32'h00);
      chk("init_done", {31'd0, init_done_out}, (k == 63) ? 32'd1 : 32'd0);
      if (k < 63) chk("init_ready", {31'd0, proc_ready_out}, 32'd0);
    end
    @(posedge clk); #1;
    chk("init_write_count", init_wr - base, 32'd64);
    chk("init_idle_we", {31'd0, bram_we_out}, 32'd0);
    chk("mem_pch", {24'd0, mem[13'h1012]}, 32'h02);
    chk("mem_pcl", {24'd0, mem[13'h1013]}, 32'h00);
    bad_bytes = 0;
    for (int a = 0; a < 64; a++)
      if (a != 18 && (!written[13'h1000 + a] || mem[13'h1000 + a] != 8'h00)) bad_bytes++;
    chk("mem_cleared", bad_bytes, 32'd0);

    proc_req("wr_ram", 1'b1, 2'd0, 12'h200, 8'hA2, 1'b1, 8'h00);
    chk("wr_ram_we", {31'd0, bram_we_out}, 32'd1);
    chk("wr_ram_addr", {19'd0, bram_addr_out}, 32'h0200);
    chk("wr_ram_din", {24'd0, bram_din_out}, 32'hA2);
    proc_req("rd_ram", 1'b0, 2'd0, 12'h200, 8'h00, 1'b1, 8'hA2);
    chk("rd_ram_addr", {19'd0, bram_addr_out}, 32'h0200);
    chk("rd_ram_we", {31'd0, bram_we_out}, 32'd0);
    proc_req("rd_pch", 1'b0, 2'd1, 12'd18, 8'h00, 1'b1, 8'h02);
    chk("rd_pch_addr", {19'd0, bram_addr_out}, 32'h1012);
    proc_req("rd_pcl", 1'b0, 2'd1, 12'd19, 8'h00, 1'b1, 8'h00);
    chk("rd_pcl_addr", {19'd0, bram_addr_out}, 32'h1013);
    idle();
    wait_drain("b2b");

    proc_req("wr_stack", 1'b1, 2'd2, 12'd5, 8'h99, 1'b1, 8'h00);
    chk("wr_stack_addr", {19'd0, bram_addr_out}, 32'h1025);
    proc_req("rd_stack", 1'b0, 2'd2, 12'd5, 8'h00, 1'b1, 8'h99);
    chk("rd_stack_addr", {19'd0, bram_addr_out}, 32'h1025);
    idle();
    wait_drain("stack");

    proc_valid_in = 1'b1; proc_we_in = 1'b0; proc_type_in = 2'd0;
    proc_addr_in = 12'h203; drv_legal = 1'b1; drv_exp = 8'h78;
    load_active_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_valid_in = 1'b1;
      load_addr_in  = 12'h200 + 12'(i);
      load_data_in  = ld_data[i];
      @(negedge clk);
      chk("load_ready", {31'd0, proc_ready_out}, 32'd0);
      @(posedge clk); #1;
      chk("load_we", {31'd0, bram_we_out}, 32'd1);
      chk("load_addr", {19'd0, bram_addr_out}, 32'h200 + i);
      chk("load_din", {24'd0, bram_din_out}, {24'd0, ld_data[i]});
    end
    load_valid_in = 1'b0;
    @(negedge clk);
    chk("load_gap_ready", {31'd0, proc_ready_out}, 32'd0);
    @(posedge clk); #1;
    chk("load_gap_we", {31'd0, bram_we_out}, 32'd0);
    load_active_in = 1'b0;
    wait_accept("held_read");
    chk("held_read_addr", {19'd0, bram_addr_out}, 32'h0203);
    proc_req("rd_load0", 1'b0, 2'd0, 12'h200, 8'h00, 1'b1, 8'h12);
    idle();
    wait_drain("load");

    proc_req("rd_inflight", 1'b0, 2'd1, 12'd18, 8'h00, 1'b1, 8'h02);
    idle();
    load_active_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    load_active_in = 1'b0;
    wait_drain("inflight");

    chk("pre_err", {31'd0, error_out}, 32'd0);
    proc_req("rd_reg_oob", 1'b0, 2'd1, 12'h025, 8'h00, 1'b0, 8'h00);
    chk("oob_we", {31'd0, bram_we_out}, 32'd0);
    chk("oob_err", {31'd0, error_out}, 32'd1);
    proc_req("rd_bad_type", 1'b0, 2'd3, 12'h000, 8'h00, 1'b0, 8'h00);
    idle();
    repeat (6) @(posedge clk);
    #1;
    chk("err_sticky", {31'd0, error_out}, 32'd1);
    wait_drain("err");

    proc_req("rd_pre_rst", 1'b0, 2'd0, 12'h201, 8'h00, 1'b1, 8'h34);
    idle();
    @(posedge clk); #1;
    rst_in = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, proc_valid_out}, 32'd0);
    base = init_wr;
    rst_in = 1'b0;
    @(posedge clk); #1;
    chk("reinit_addr", {19'd0, bram_addr_out}, 32'h1000);
    chk("reinit_we", {31'd0, bram_we_out}, 32'd1);
    chk("reinit_done", {31'd0, init_done_out}, 32'd0);
    chk("reinit_err", {31'd0, error_out}, 32'd0);
    repeat (64) @(posedge clk);
    #1;
    chk("reinit_count", init_wr - base, 32'd64);
    chk("reinit_done_hi", {31'd0, init_done_out}, 32'd1);
    chk("reinit_ready", {31'd0, proc_ready_out}, 32'd1);
    wait_drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
